// File: rtl/m72_bg_pkg.sv
// ---------------------------------------------------------------------------
// m72_bg_pkg
// Shared definitions for the M72 background tile fetcher:
//   - bg_state_t : fetch FSM states (IDLE, VR0, VR1, ROM, FULL)
//   - VRAM tilemap entry field positions
//       word0: code[CODE_MSB:0], fy at FY_BIT, fx at FX_BIT
//       word1: pal[PAL_LSB+3:PAL_LSB], prio[PRIO_LSB+1:PRIO_LSB]
//   - default address widths for VRAM and GFX ROM
// ---------------------------------------------------------------------------
package m72_bg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_VR0  = 3'd1,
        ST_VR1  = 3'd2,
        ST_ROM  = 3'd3,
        ST_FULL = 3'd4
    } bg_state_t;

    localparam int CODE_MSB = 13;
    localparam int FY_BIT   = 14;
    localparam int FX_BIT   = 15;
    localparam int PAL_LSB  = 0;
    localparam int PRIO_LSB = 4;

    localparam int VRAM_AW_DEF = 13;
    localparam int ROM_AW_DEF  = 17;

endpackage

// File: rtl/m72_bg_tile_fetch.sv
// ---------------------------------------------------------------------------
// m72_bg_tile_fetch
// Feeds one background layer's 4-plane colour shift register. For each
// 8-pixel tile column it reads the two tilemap words from VRAM and the tile
// row (4 plane bytes) from GFX ROM into a single staging buffer, then hands
// the bytes over on LOAD with flip/palette/priority aligned to that edge.
// The next column is fetched while the current one shifts out.
//
// Optional feature macro: BG_UNDERRUN_CNT_EN adds underrun_cnt[7:0], a
// saturating count of consumes that found no staged data (since reset).
//
// Ports:
//   clock, reset            system clock, async active-high reset
//   CE_PIXEL, tile_tick     pixel enable and tile consume point
//   line_start              hblank pulse, primes the fetch for the next line
//   y[8:0], col_start[5:0]  scrolled layer row and first tile column
//   vram_req/addr/ack/data  VRAM word read handshake
//   rom_req/addr/ack/data   GFX ROM row read handshake
//   LOAD, byte_1..byte_4    shift register load strobe and plane bytes
//   flip_x, pal, prio       attributes of the pixels currently shifting
//   underrun                sticky, set when a consume finds no data
// ---------------------------------------------------------------------------
module m72_bg_tile_fetch
    import m72_bg_pkg::*;
#(
    parameter int VRAM_AW = VRAM_AW_DEF,
    parameter int ROM_AW  = ROM_AW_DEF
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               CE_PIXEL,
    input  logic               line_start,
    input  logic               tile_tick,
    input  logic [8:0]         y,
    input  logic [5:0]         col_start,
    output logic               vram_req,
    output logic [VRAM_AW-1:0] vram_addr,
    input  logic               vram_ack,
    input  logic [15:0]        vram_data,
    output logic               rom_req,
    output logic [ROM_AW-1:0]  rom_addr,
    input  logic               rom_ack,
    input  logic [31:0]        rom_data,
    output logic               LOAD,
    output logic [7:0]         byte_1,
    output logic [7:0]         byte_2,
    output logic [7:0]         byte_3,
    output logic [7:0]         byte_4,
    output logic               flip_x,
    output logic [3:0]         pal,
    output logic [1:0]         prio,
    output logic               underrun
`ifdef BG_UNDERRUN_CNT_EN
    ,
    output logic [7:0]         underrun_cnt
`endif
);

    bg_state_t          r_state;
    logic               r_restart;      // line_start arrived while a request was outstanding
    logic [5:0]         r_col;
    logic               r_vram_req;
    logic [VRAM_AW-1:0] r_vram_addr;
    logic               r_rom_req;
    logic [ROM_AW-1:0]  r_rom_addr;
    logic               r_stg_valid;
    logic               r_flip_x;
    logic [3:0]         r_pal;
    logic [1:0]         r_prio;
    logic               r_underrun;

    // Tilemap entry being fetched and the staged column (data path, no reset)
    logic [CODE_MSB:0]  r_code;
    logic               r_fy;
    logic               r_fx;
    logic [3:0]         r_pal_n;
    logic [1:0]         r_prio_n;
    logic [31:0]        r_stg_data;
    logic               r_stg_fx;
    logic [3:0]         r_stg_pal;
    logic [1:0]         r_stg_prio;

    logic               w_consume;
    logic               w_fetch_ok;
    logic               w_ld_w0;
    logic               w_ld_w1;
    logic               w_ld_rom;

    assign w_consume  = CE_PIXEL & tile_tick;
    // Normal fetch progress is suspended while a line restart is pending
    assign w_fetch_ok = ~line_start & ~r_restart;
    assign w_ld_w0    = w_fetch_ok && (r_state == ST_VR0) && r_vram_req && vram_ack;
    assign w_ld_w1    = w_fetch_ok && (r_state == ST_VR1) && r_vram_req && vram_ack;
    assign w_ld_rom   = w_fetch_ok && (r_state == ST_ROM) && r_rom_req  && rom_ack;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_restart   <= 1'b0;
            r_col       <= '0;
            r_vram_req  <= 1'b0;
            r_vram_addr <= '0;
            r_rom_req   <= 1'b0;
            r_rom_addr  <= '0;
            r_stg_valid <= 1'b0;
            r_flip_x    <= 1'b0;
            r_pal       <= '0;
            r_prio      <= '0;
            r_underrun  <= 1'b0;
        end else begin
            // Consume sees the staging state as it was before this edge
            if (w_consume) begin
                r_flip_x    <= r_stg_valid & r_stg_fx;
                r_pal       <= r_stg_valid ? r_stg_pal  : 4'h0;
                r_prio      <= r_stg_valid ? r_stg_prio : 2'h0;
                r_stg_valid <= 1'b0;
                if (!r_stg_valid)
                    r_underrun <= 1'b1;
            end

            if (line_start) begin
                r_col       <= col_start;
                r_underrun  <= 1'b0;
                r_stg_valid <= 1'b0;
                // An unanswered request must see its ack before restarting
                if ((r_vram_req && !vram_ack) || (r_rom_req && !rom_ack)) begin
                    r_restart <= 1'b1;
                end else begin
                    r_restart  <= 1'b0;
                    r_vram_req <= 1'b0;
                    r_rom_req  <= 1'b0;
                    r_state    <= ST_VR0;
                end
            end else if (r_restart) begin
                // Drain the stale request; its data is dropped
                if ((r_vram_req && vram_ack) || (r_rom_req && rom_ack)) begin
                    r_restart  <= 1'b0;
                    r_vram_req <= 1'b0;
                    r_rom_req  <= 1'b0;
                    r_state    <= ST_VR0;
                end
            end else begin
                // Each fetch state issues its request when req is low and
                // advances on the ack, so req always drops for a cycle.
                case (r_state)
                    ST_IDLE: begin
                        if (w_consume)
                            r_state <= ST_VR0;
                    end
                    ST_VR0: begin
                        if (!r_vram_req) begin
                            r_vram_req  <= 1'b1;
                            r_vram_addr <= VRAM_AW'({y[8:3], r_col, 1'b0});
                        end else if (vram_ack) begin
                            r_vram_req <= 1'b0;
                            r_state    <= ST_VR1;
                        end
                    end
                    ST_VR1: begin
                        if (!r_vram_req) begin
                            r_vram_req  <= 1'b1;
                            r_vram_addr <= VRAM_AW'({y[8:3], r_col, 1'b1});
                        end else if (vram_ack) begin
                            r_vram_req <= 1'b0;
                            r_state    <= ST_ROM;
                        end
                    end
                    ST_ROM: begin
                        if (!r_rom_req) begin
                            r_rom_req  <= 1'b1;
                            r_rom_addr <= ROM_AW'({r_code, y[2:0] ^ {3{r_fy}}});
                        end else if (rom_ack) begin
                            r_rom_req   <= 1'b0;
                            r_stg_valid <= 1'b1;
                            r_col       <= r_col + 6'd1;
                            r_state     <= ST_FULL;
                        end
                    end
                    ST_FULL: begin
                        if (w_consume)
                            r_state <= ST_VR0;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clock) begin
        if (w_ld_w0) begin
            r_code <= vram_data[CODE_MSB:0];
            r_fy   <= vram_data[FY_BIT];
            r_fx   <= vram_data[FX_BIT];
        end
        if (w_ld_w1) begin
            r_pal_n  <= vram_data[PAL_LSB +: 4];
            r_prio_n <= vram_data[PRIO_LSB +: 2];
        end
        if (w_ld_rom) begin
            r_stg_data <= rom_data;
            r_stg_fx   <= r_fx;
            r_stg_pal  <= r_pal_n;
            r_stg_prio <= r_prio_n;
        end
    end

`ifdef BG_UNDERRUN_CNT_EN
    logic [7:0] r_underrun_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_underrun_cnt <= '0;
        else if (w_consume && !r_stg_valid && r_underrun_cnt != 8'hFF)
            r_underrun_cnt <= r_underrun_cnt + 8'd1;
    end

    assign underrun_cnt = r_underrun_cnt;
`else
    // Without the counter only the sticky underrun flag is kept.
`endif

    assign vram_req  = r_vram_req;
    assign vram_addr = r_vram_addr;
    assign rom_req   = r_rom_req;
    assign rom_addr  = r_rom_addr;
    assign LOAD      = w_consume;
    // Empty staging loads transparent pixels
    assign byte_1    = r_stg_valid ? r_stg_data[7:0]   : 8'h00;
    assign byte_2    = r_stg_valid ? r_stg_data[15:8]  : 8'h00;
    assign byte_3    = r_stg_valid ? r_stg_data[23:16] : 8'h00;
    assign byte_4    = r_stg_valid ? r_stg_data[31:24] : 8'h00;
    assign flip_x    = r_flip_x;
    assign pal       = r_pal;
    assign prio      = r_prio;
    assign underrun  = r_underrun;

endmodule
